// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
// 8N1 UART receiver: resynchronises din, rejects start glitches, delivers bytes on valid/ready,
// flags framing errors and overruns. Outputs update one clk after the stop-bit sample.
module uart_rx_byte #(
  parameter int SYSTEM_CLOCK = 32000000,
  parameter int BAUD_RATE    = 9600,
  parameter int CYC_COUNT    = SYSTEM_CLOCK / BAUD_RATE,
  parameter int HALF_COUNT   = CYC_COUNT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (CYC_COUNT > 1) ? $clog2(CYC_COUNT) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYC_COUNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_COUNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          din_m, din_s;
  logic          done_ok, done_ok_n;
  logic          done_err, done_err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b1;
      din_s <= 1'b1;
    end else begin
      din_m <= din;
      din_s <= din_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      done_ok  <= 1'b0;
      done_err <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      done_ok  <= done_ok_n;
      done_err <= done_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shift_n    = shift;
    done_ok_n  = 1'b0;
    done_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!din_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt == HALF_LAST) begin
          if (din_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            cnt_n   = '0;
            idx_n   = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CYC_LAST) begin
          shift_n = {din_s, shift[7:1]};
          cnt_n   = '0;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CYC_LAST) begin
          cnt_n = '0;
          if (din_s) begin
            done_ok_n = 1'b1;
            state_n   = IDLE;
          end else begin
            done_err_n = 1'b1;
            state_n    = BREAK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is accepted.
        if (din_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= done_err;
      overrun   <= 1'b0;
      if (done_ok) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// Bench for uart_rx_byte at 16 clk per bit: scoreboard of expected bytes popped on each
// rx_valid && rx_ready handshake, plus per-scenario checks of pulses, timing and reset values.
module tb_uart_rx_byte;

  localparam int CYC  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] q[$];

  uart_rx_byte #(.SYSTEM_CLOCK(16), .BAUD_RATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted byte must match the oldest expected one.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
    if (rst_n && rx_valid && rx_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: got %02h, none expected", rx_data);
      end else begin
        logic [7:0] exp;
        exp = q.pop_front();
        if (rx_data !== exp) begin
          miscompares++;
          $display("FAIL byte_data: got %02h, expected %02h", rx_data, exp);
        end
      end
    end
  end

  // Call right after a posedge (+#1); returns 160 cycles later with din left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      din = f[i];
      repeat (CYC) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_queue_empty(input string name);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d bytes never delivered, expected 0", name, q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 4;
    if (rx_data !== 8'h00)  begin miscompares++; $display("FAIL rst_data: got %02h, expected 00", rx_data); end
    if (rx_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_valid: got %b, expected 0", rx_valid); end
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_frame_err: got %b, expected 0", frame_err); end
    if (overrun !== 1'b0)   begin miscompares++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    int t0, t_rise;
    bit seen;
    logic v_after;
    seen = 0; t_rise = 0; v_after = 1'bx;
    rx_ready = 1'b1;
    q.push_back(8'hA5);
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 300 && !seen; i++) begin
          @(negedge clk);
          if (rx_valid) begin
            seen = 1; t_rise = cyc;
            @(negedge clk);
            v_after = rx_valid;
          end
        end
      end
    join
    // 3 = two synchroniser flops plus the IDLE edge that sees din_s low.
    vectors += 2;
    if (!seen || (t_rise - t0) != 3 + HALF + 9 * CYC + 1) begin
      miscompares++;
      $display("FAIL a5_latency: seen=%0d after %0d cycles, expected %0d", seen, t_rise - t0, 3 + HALF + 9 * CYC + 1);
    end
    if (v_after !== 1'b0) begin
      miscompares++;
      $display("FAIL a5_pulse_width: rx_valid %b one cycle later, expected 0", v_after);
    end
    idle(10);
    check_queue_empty("a5_delivered");
  endtask

  task automatic test_back_to_back();
    int ov0;
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(10);
    vectors += 3;
    if (ov_cnt - ov0 != 1) begin miscompares++; $display("FAIL overrun_count: got %0d, expected 1", ov_cnt - ov0); end
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL overrun_valid: got %b, expected 1", rx_valid); end
    if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL overrun_data: got %02h, expected 3c", rx_data); end
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL overrun_drain: rx_valid %b, expected 0", rx_valid); end
    idle(2);
    check_queue_empty("overrun_delivered");
  endtask

  task automatic test_frame_err();
    int fe0;
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle(40);
    din = 1'b1;
    idle(20);
    vectors++;
    if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL frame_err_count: got %0d, expected 1", fe_cnt - fe0); end
    q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle(10);
    check_queue_empty("after_break_12");
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    din = 1'b0;
    idle(4);
    din = 1'b1;
    idle(5);
    // Real frame starts right behind the glitch; it decodes only if the FSM is back in IDLE.
    q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(10);
    vectors++;
    if (fe_cnt != fe0) begin miscompares++; $display("FAIL glitch_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); end
    check_queue_empty("after_glitch_5a");
  endtask

  task automatic test_reset_mid();
    int fe0;
    fe0 = fe_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        idle(3 * CYC);
        rst_n = 1'b0;
        @(negedge clk);
        vectors += 4;
        if (rx_data !== 8'h00)  begin miscompares++; $display("FAIL midrst_data: got %02h, expected 00", rx_data); end
        if (rx_valid !== 1'b0)  begin miscompares++; $display("FAIL midrst_valid: got %b, expected 0", rx_valid); end
        if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_err: got %b, expected 0", frame_err); end
        if (overrun !== 1'b0)   begin miscompares++; $display("FAIL midrst_overrun: got %b, expected 0", overrun); end
        idle(4);
        rst_n = 1'b1;
      end
    join
    idle(CYC * 2);
    vectors += 2;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_spurious: rx_valid %b, expected 0", rx_valid); end
    if (fe_cnt != fe0) begin miscompares++; $display("FAIL midrst_frame_err_count: got %0d, expected 0", fe_cnt - fe0); end
    q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(10);
    check_queue_empty("after_reset_0f");
  endtask

  task automatic test_simultaneous();
    int ov0;
    rx_ready = 1'b0;
    q.push_back(8'h21);
    send_frame(8'h21, 1'b1);
    idle(10);
    vectors++;
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL sim_setup_valid: got %b, expected 1", rx_valid); end
    ov0 = ov_cnt;
    q.push_back(8'h77);
    fork
      send_frame(8'h77, 1'b1);
      begin
        // Handshake of 8'h21 lands on the same edge that completes 8'h77.
        idle(3 + HALF + 9 * CYC);
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL sim_valid: got %b, expected 1", rx_valid); end
        if (rx_data !== 8'h77) begin miscompares++; $display("FAIL sim_data: got %02h, expected 77", rx_data); end
      end
    join
    vectors++;
    if (ov_cnt != ov0) begin miscompares++; $display("FAIL sim_overrun: got %0d pulses, expected 0", ov_cnt - ov0); end
    rx_ready = 1'b1;
    idle(4);
    check_queue_empty("sim_delivered");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
